// File: rtl/cdc_xfer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdc_xfer_pkg : shared types and default sizing for the cdc_xfer_arb slice   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package cdc_xfer_pkg;

   localparam int c_N_REQ       = 4;
   localparam int c_DW          = 4;
   localparam int c_SYNC_STAGES = 2;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } a_state_e;

   // Fold an index that has run at most one lap past n back into 0..n-1.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdc_sync_bit : multi-flop single-bit synchronizer, async active-high reset  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_xfer_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdc_xfer_arb : round-robin arbiter feeding a toggle-handshake payload CDC   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module cdc_xfer_arb
   import cdc_xfer_pkg::*;
#(
   parameter  int N_REQ       = c_N_REQ,
   parameter  int DW          = c_DW,
   parameter  int SYNC_STAGES = c_SYNC_STAGES,
   localparam int SRC_W       = $clog2(N_REQ)
) (
   input  logic                  a_clk,
   input  logic                  a_rst_n,
   input  logic                  b_clk,
   input  logic                  b_rst_n,
   input  logic [N_REQ-1:0]      a_req,
   input  logic [N_REQ*DW-1:0]   a_data,
   output logic [N_REQ-1:0]      a_done,
   output logic                  a_busy,
   output logic                  b_valid,
   output logic [DW-1:0]         b_data,
   output logic [SRC_W-1:0]      b_src
);

   // ---------------- a_clk domain ----------------
   a_state_e             r_state;
   a_state_e             w_state_nxt;
   logic                 r_req_tgl;
   logic [SRC_W-1:0]     r_rr_ptr;
   logic [SRC_W-1:0]     r_hold_src;
   logic [DW-1:0]        r_hold_data;
   logic [N_REQ-1:0]     r_done;
   logic                 r_busy;

   logic                 w_ack_sync;
   logic                 w_ack_match;
   logic                 w_grant_found;
   logic [SRC_W-1:0]     w_grant_idx;
   logic                 w_do_grant;
   logic                 w_do_done;
   logic [SRC_W-1:0]     w_rr_nxt;

   // Search starts at the pointer and wraps, so the last winner goes to the back.
   always_comb begin
      int idx;
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      idx           = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = rr_wrap(int'(r_rr_ptr) + i, N_REQ);
         if (!w_grant_found && a_req[idx]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = SRC_W'(idx);
         end
      end
   end

   assign w_ack_match = (w_ack_sync == r_req_tgl);
   assign w_rr_nxt    = (r_hold_src == SRC_W'(N_REQ - 1)) ? '0 : r_hold_src + SRC_W'(1);

   always_ff @(posedge a_clk or posedge a_rst_n) begin
      if (a_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (w_grant_found) w_state_nxt = ST_WAIT_ACK;
         ST_WAIT_ACK: if (w_ack_match)   w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_do_grant = 1'b0;
      w_do_done  = 1'b0;
      case (r_state)
         ST_IDLE:     w_do_grant = w_grant_found;
         ST_WAIT_ACK: w_do_done  = w_ack_match;
         default:     ;
      endcase
   end

   // Hold registers only load on grant, so they are frozen for the whole handshake.
   always_ff @(posedge a_clk or posedge a_rst_n) begin
      if (a_rst_n) begin
         r_req_tgl   <= 1'b0;
         r_rr_ptr    <= '0;
         r_hold_src  <= '0;
         r_hold_data <= '0;
         r_done      <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_done <= '0;
         if (w_do_grant) begin
            r_hold_data <= a_data[w_grant_idx*DW +: DW];
            r_hold_src  <= w_grant_idx;
            r_req_tgl   <= ~r_req_tgl;
            r_busy      <= 1'b1;
         end
         if (w_do_done) begin
            r_done   <= {{(N_REQ-1){1'b0}}, 1'b1} << r_hold_src;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_rr_nxt;
         end
      end
   end

   assign a_done = r_done;
   assign a_busy = r_busy;

   // ---------------- b_clk domain ----------------
   logic                 w_req_sync;
   logic                 r_req_sync_q;
   logic                 r_ack_tgl;
   logic                 r_b_valid;
   logic [DW-1:0]        r_b_data;
   logic [SRC_W-1:0]     r_b_src;
   logic                 w_req_edge;

   assign w_req_edge = w_req_sync ^ r_req_sync_q;

   always_ff @(posedge b_clk or posedge b_rst_n) begin
      if (b_rst_n) begin
         r_req_sync_q <= 1'b0;
         r_ack_tgl    <= 1'b0;
         r_b_valid    <= 1'b0;
         r_b_data     <= '0;
         r_b_src      <= '0;
      end else begin
         r_req_sync_q <= w_req_sync;
         r_b_valid    <= w_req_edge;
         if (w_req_edge) begin
            r_b_data  <= r_hold_data;
            r_b_src   <= r_hold_src;
            r_ack_tgl <= w_req_sync;
         end
      end
   end

   assign b_valid = r_b_valid;
   assign b_data  = r_b_data;
   assign b_src   = r_b_src;

   // ---------------- synchronizers ----------------
   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .i_clk (b_clk),
      .i_rst (b_rst_n),
      .i_d   (r_req_tgl),
      .o_q   (w_req_sync)
   );

   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .i_clk (a_clk),
      .i_rst (a_rst_n),
      .i_d   (r_ack_tgl),
      .o_q   (w_ack_sync)
   );

endmodule
`default_nettype wire

// File: tb/tb_cdc_xfer_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cdc_xfer_arb : randomized self-checking bench for cdc_xfer_arb           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_cdc_xfer_arb;

   localparam int N  = 4;
   localparam int DW = 4;

   logic           a_clk, b_clk, a_rst_n, b_rst_n;
   logic [N-1:0]   a_req;
   logic [N*DW-1:0] a_data;
   logic [N-1:0]   a_done;
   logic           a_busy, b_valid;
   logic [DW-1:0]  b_data;
   logic [1:0]     b_src;

   int a_half = 5;
   int b_half = 7;
   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;
   logic [5:0] b_log[$];

   cdc_xfer_arb #(.N_REQ(N), .DW(DW), .SYNC_STAGES(2)) dut (
      .a_clk(a_clk), .a_rst_n(a_rst_n), .b_clk(b_clk), .b_rst_n(b_rst_n),
      .a_req(a_req), .a_data(a_data), .a_done(a_done), .a_busy(a_busy),
      .b_valid(b_valid), .b_data(b_data), .b_src(b_src)
   );

   initial begin a_clk = 1'b0; forever #(a_half) a_clk = ~a_clk; end
   initial begin b_clk = 1'b0; forever #(b_half) b_clk = ~b_clk; end

   always @(negedge b_clk) if (b_valid === 1'b1) b_log.push_back({b_src, b_data});

   // Reference: first requesting index at or after the pointer, wrapping.
   function automatic int model_grant(input logic [N-1:0] req);
      for (int i = 0; i < N; i++)
         if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   task automatic apply_reset(input bit chk);
      a_req = '0; a_data = '0;
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      repeat (4) @(posedge b_clk);
      repeat (4) @(posedge a_clk);
      if (chk) begin
         checks++; if (a_done !== '0)   begin errors++; $display("FAIL rst_a_done got=%b exp=0000", a_done); end
         checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_a_busy got=%b exp=0", a_busy); end
         checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got=%b exp=0", b_valid); end
         checks++; if (b_data !== '0)   begin errors++; $display("FAIL rst_b_data got=%h exp=0", b_data); end
         checks++; if (b_src !== '0)    begin errors++; $display("FAIL rst_b_src got=%0d exp=0", b_src); end
      end
      @(negedge a_clk);
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      repeat (3) @(negedge a_clk);
      b_log.delete();
      m_ptr = 0;
   endtask

   // Caller is at an a_clk negedge with the DUT idle; returns at a negedge, idle.
   task automatic serve_one(input logic [N-1:0] req, input logic [N*DW-1:0] data, input bit drop,
                            output int got_src, output logic [DW-1:0] got_data);
      int k, cyc;
      bit busy_bad;
      logic [5:0] ev;
      logic [DW-1:0] exp_d;
      k = model_grant(req);
      exp_d = data[k*DW +: DW];
      got_src = -1; got_data = 'x;
      a_req = req; a_data = data;
      @(posedge a_clk); #1;
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_on_grant got=%b exp=1", a_busy); end
      @(negedge a_clk);
      if (drop) a_req = '0;
      busy_bad = 1'b0; cyc = 0;
      while (a_done === '0 && cyc < 400) begin
         if (a_busy !== 1'b1) busy_bad = 1'b1;
         @(negedge a_clk); cyc++;
      end
      a_req = '0;
      checks++;
      if (cyc >= 400) begin
         errors++; $display("FAIL done_timeout got=no_a_done exp=a_done[%0d]", k);
         return;
      end
      checks++; if (busy_bad) begin errors++; $display("FAIL busy_gap got=a_busy_low exp=high_until_done"); end
      checks++;
      if (a_done !== (4'b0001 << k) || a_busy !== 1'b0) begin
         errors++; $display("FAIL done_pulse got=done:%b busy:%b exp=done:%b busy:0", a_done, a_busy, 4'b0001 << k);
      end
      checks++;
      if (b_log.size() != 1) begin
         errors++; $display("FAIL b_valid_count got=%0d exp=1", b_log.size());
      end
      if (b_log.size() > 0) begin
         ev = b_log.pop_front();
         got_src = int'(ev[5:4]); got_data = ev[3:0];
         checks++;
         if (got_src != k || got_data !== exp_d) begin
            errors++; $display("FAIL payload got=src%0d/%h exp=src%0d/%h", got_src, got_data, k, exp_d);
         end
      end
      b_log.delete();
      @(negedge a_clk);
      checks++; if (a_done !== '0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL done_one_cycle got=done:%b busy:%b exp=0000/0", a_done, a_busy);
      end
      m_ptr = (k + 1) % N;
   endtask

   task automatic test_reset();
      apply_reset(1'b1);
      checks++; if (a_busy !== 1'b0 || a_done !== '0 || b_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset got=busy:%b done:%b valid:%b exp=0/0000/0", a_busy, a_done, b_valid);
      end
   endtask

   task automatic test_single();
      int s; logic [DW-1:0] d;
      serve_one(4'b0100, 16'h0A00, 1'b0, s, d);
      checks++; if (s != 2 || d !== 4'hA) begin errors++; $display("FAIL single got=src%0d/%h exp=src2/a", s, d); end
   endtask

   task automatic test_round_robin();
      int s; logic [DW-1:0] d;
      int exp_s[5] = '{0, 1, 2, 3, 0};
      apply_reset(1'b0);
      for (int i = 0; i < 5; i++) begin
         serve_one(4'b1111, 16'h4321, 1'b0, s, d);
         checks++;
         if (s != exp_s[i] || d !== DW'(exp_s[i] + 1)) begin
            errors++; $display("FAIL rr_seq[%0d] got=src%0d/%h exp=src%0d/%0d", i, s, d, exp_s[i], exp_s[i] + 1);
         end
      end
   endtask

   task automatic test_wrap();
      int s; logic [DW-1:0] d;
      serve_one(4'b1000, 16'h7000, 1'b0, s, d);
      serve_one(4'b1001, 16'h7006, 1'b0, s, d);
      checks++; if (s != 0 || d !== 4'h6) begin errors++; $display("FAIL wrap got=src%0d/%h exp=src0/6", s, d); end
   endtask

   task automatic test_drop();
      int s; logic [DW-1:0] d;
      serve_one(4'b0010, 16'h0050, 1'b1, s, d);
      checks++; if (s != 1 || d !== 4'h5) begin errors++; $display("FAIL drop got=src%0d/%h exp=src1/5", s, d); end
   endtask

   task automatic test_random(input int n);
      int s; logic [DW-1:0] d;
      for (int i = 0; i < n; i++)
         serve_one(N'($urandom_range(1, 15)), (N*DW)'($urandom), 1'($urandom_range(0, 1)), s, d);
   endtask

   task automatic test_ratio(input int ah, input int bh);
      apply_reset(1'b0);
      a_half = ah; b_half = bh;
      repeat (4) @(negedge a_clk);
      test_random(20);
   endtask

   task automatic test_reset_mid();
      int s; logic [DW-1:0] d;
      a_req = 4'b0010; a_data = 16'h00C0;
      @(posedge a_clk); #1;
      @(negedge a_clk); a_req = '0;
      @(negedge a_clk);
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", a_busy); end
      apply_reset(1'b1);
      serve_one(4'b0100, 16'h0900, 1'b0, s, d);
      checks++; if (s != 2 || d !== 4'h9) begin errors++; $display("FAIL after_mid_reset got=src%0d/%h exp=src2/9", s, d); end
   endtask

   initial begin
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      a_req = '0; a_data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_drop();
      test_random(25);
      test_ratio(5, 15);
      test_ratio(15, 5);
      a_half = 5; b_half = 7;
      repeat (4) @(negedge a_clk);
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cdc_xfer_arb.md
CDC_XFER_ARB -- requirements
Module: cdc_xfer_arb

Interface
REQ-001 Parameter N_REQ, 4, number of a_clk-domain requesters (2..8).
REQ-002 Parameter DW, 4, payload width per requester.
REQ-003 Parameter SYNC_STAGES, 2, flop count of each toggle synchronizer (min 2).
REQ-004 Reset a_rst_n, asynchronous, active-high; clock a_clk.
REQ-005 Port a_clk  input  1  source-domain clock.
REQ-006 Port a_rst_n  input  1  source-domain reset, asynchronous, active-high.
REQ-007 Port b_clk  input  1  destination-domain clock.
REQ-008 Port b_rst_n  input  1  destination-domain reset, asynchronous, active-high.
REQ-009 Port a_req  input  N_REQ  per-requester transfer request, level, a_clk.
REQ-010 Port a_data  input  N_REQ*DW  per-requester payload, slice i belongs to a_req[i].
REQ-011 Port a_done  output  N_REQ  one-cycle completion pulse per requester, a_clk.
REQ-012 Port a_busy  output  1  high while a transfer is outstanding, a_clk.
REQ-013 Port b_valid  output  1  one-cycle delivery pulse, b_clk.
REQ-014 Port b_data  output  DW  delivered payload, held until next delivery.
REQ-015 Port b_src  output  clog2(N_REQ)  index of the requester that sourced b_data.

Function
REQ-016 A-side FSM SHALL have states IDLE and WAIT_ACK only.
REQ-017 IDLE with any a_req bit high: grant round-robin, first set bit at or above rr_ptr, wrapping N_REQ-1 -> 0.
REQ-018 On grant: latch a_data slice and index into hold_data/hold_src, toggle req_tgl, assert a_busy, enter WAIT_ACK, all on the same edge.
REQ-019 hold_data, hold_src and req_tgl SHALL remain stable throughout WAIT_ACK.
REQ-020 WAIT_ACK exits when synchronized ack_tgl equals req_tgl: pulse a_done[granted] one cycle, deassert a_busy, set rr_ptr = granted+1 (mod N_REQ), return to IDLE.
REQ-021 Arbitration resumes no earlier than the a_clk edge after a_done; at most one transfer outstanding.
REQ-022 a_req deasserted after grant SHALL NOT abort the transfer; a_done still pulses.
REQ-023 B side: req_tgl passes through SYNC_STAGES flops; edge detector against previous synced value.
REQ-024 On detected change: capture hold_data/hold_src into b_data/b_src, pulse b_valid one b_clk cycle, set ack_tgl to synced req_tgl, same edge.
REQ-025 Latency grant -> b_valid SHALL be SYNC_STAGES+1 b_clk edges max plus one b_clk period for phase; b_valid -> a_done SHALL be SYNC_STAGES+1 a_clk edges max plus one a_clk period for phase.
REQ-026 hold_data/hold_src SHALL be the only data crossing domains unsynchronized; stability guaranteed by REQ-019.

Reset
REQ-027 a_rst_n high: FSM IDLE, req_tgl 0, rr_ptr 0, a_done 0, a_busy 0, a-side sync flops 0, hold regs 0.
REQ-028 b_rst_n high: ack_tgl 0, b-side sync flops 0, b_valid 0, b_data 0, b_src 0.
REQ-029 Both resets SHALL be asserted together for at least 3 cycles of the slower clock; independent single-domain reset mid-transfer is unsupported.

Structure
REQ-030 Package cdc_xfer_pkg SHALL hold the FSM state typedef and default N_REQ/DW/SYNC_STAGES constants.
REQ-031 Sub-module cdc_sync_bit (SYNC_STAGES-flop single-bit synchronizer, async active-high reset) SHALL be instantiated twice: req path into b_clk, ack path into a_clk.

Verification
REQ-032 Single request: a_req=4'b0100, a_data[11:8]=4'hA -> one b_valid, b_data=4'hA, b_src=2; then a_done=4'b0100 once.
REQ-033 All requests held: a_req=4'b1111, data 1,2,3,4 -> b_src sequence 0,1,2,3,0 with matching data; no requester starved.
REQ-034 Pointer wrap: after grant to 3, a_req=4'b1001 -> next grant 0, not 3.
REQ-035 Clock ratios a:b = 1:3 and 3:1 -> exactly one b_valid per a_done, payload never corrupted, a_busy never low during a transfer.
REQ-036 Request dropped after grant: a_req[1] pulsed one cycle, data 4'h5 -> b_data=4'h5, b_src=1, a_done[1] pulses.
REQ-037 Both resets asserted during WAIT_ACK -> all outputs reach REQ-027/028 values; next request completes normally.
